// File: rtl/aes_pkg.sv
// Shared AES definitions: keylen codes, round counts, FSM encoding and
// the byte-level helpers used by the encipher datapath.
package aes_pkg;

   localparam logic [3:0] AES_128_BIT_KEY = 4'h0;
   localparam logic [3:0] AES_192_BIT_KEY = 4'h1;
   localparam logic [3:0] AES_256_BIT_KEY = 4'h2;

   localparam logic [3:0] AES_128_NUM_ROUNDS = 4'd10;
   localparam logic [3:0] AES_192_NUM_ROUNDS = 4'd12;
   localparam logic [3:0] AES_256_NUM_ROUNDS = 4'd14;

   typedef enum logic [1:0] {
      CTRL_IDLE,
      CTRL_INIT,
      CTRL_SBOX,
      CTRL_MAIN
   } ctrl_e;

   // xtime: multiply by x in GF(2^8) modulo 0x11b.
   function automatic logic [7:0] gm2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [7:0] gm3(input logic [7:0] b);
      return gm2(b) ^ b;
   endfunction

   // Byte n of the state sits at [127-8n -: 8]; row = n % 4, column = n / 4.
   function automatic logic [127:0] shiftrows(input logic [127:0] s);
      logic [31:0] w0, w1, w2, w3;
      w0 = {s[127:120], s[87:80],   s[47:40],  s[7:0]};
      w1 = {s[95:88],   s[55:48],   s[15:8],   s[103:96]};
      w2 = {s[63:56],   s[23:16],   s[111:104], s[71:64]};
      w3 = {s[31:24],   s[119:112], s[79:72],  s[39:32]};
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [3:0] rounds_for(input logic [3:0] keylen);
      logic [3:0] nr;
      unique case (keylen)
         AES_192_BIT_KEY: nr = AES_192_NUM_ROUNDS;
         AES_256_BIT_KEY: nr = AES_256_NUM_ROUNDS;
         default:         nr = AES_128_NUM_ROUNDS;
      endcase
      return nr;
   endfunction

endpackage

// File: rtl/aes_mixcolumns_word.sv
// MixColumns applied to a single 32-bit state column.
module aes_mixcolumns_word
   import aes_pkg::*;
(
   input  logic [31:0] col,
   output logic [31:0] mixed
);

   logic [7:0] b0, b1, b2, b3;

   assign b0 = col[31:24];
   assign b1 = col[23:16];
   assign b2 = col[15:8];
   assign b3 = col[7:0];

   assign mixed = {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
                   b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
                   b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
                   gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};

endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES encipher datapath: one SubBytes word per cycle through the
// shared external s_box, then ShiftRows/MixColumns/AddRoundKey in one cycle.
module aes_encipher_block
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         next,
   input  logic [3:0]   keylen,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   output logic [31:0]  sboxw,
   input  logic [31:0]  new_sboxw,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready
);

   ctrl_e        ctrl_q;
   logic [127:0] state_q;
   logic [1:0]   word_ctr_q;
   logic [3:0]   num_rounds_q;

   logic [127:0] sr_state;
   logic [127:0] mc_state;
   logic [127:0] sbox_state;

   assign sr_state  = shiftrows(state_q);
   assign new_block = state_q;

   for (genvar i = 0; i < 4; i++) begin : g_mixcol
      aes_mixcolumns_word u_mixcol (
         .col   (sr_state[127-32*i -: 32]),
         .mixed (mc_state[127-32*i -: 32])
      );
   end

   always_comb begin
      sboxw = 32'h0;
      unique case (word_ctr_q)
         2'd0: sboxw = state_q[127:96];
         2'd1: sboxw = state_q[95:64];
         2'd2: sboxw = state_q[63:32];
         2'd3: sboxw = state_q[31:0];
         default: sboxw = 32'h0;
      endcase
   end

   always_comb begin
      sbox_state = state_q;
      unique case (word_ctr_q)
         2'd0: sbox_state[127:96] = new_sboxw;
         2'd1: sbox_state[95:64]  = new_sboxw;
         2'd2: sbox_state[63:32]  = new_sboxw;
         2'd3: sbox_state[31:0]   = new_sboxw;
         default: sbox_state = state_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q       <= CTRL_IDLE;
         state_q      <= 128'h0;
         word_ctr_q   <= 2'd0;
         num_rounds_q <= AES_128_NUM_ROUNDS;
         round        <= 4'd0;
         ready        <= 1'b1;
      end else begin
         unique case (ctrl_q)
            CTRL_IDLE: begin
               if (next) begin
                  ready        <= 1'b0;
                  round        <= 4'd0;
                  num_rounds_q <= rounds_for(keylen);
                  ctrl_q       <= CTRL_INIT;
               end
            end
            CTRL_INIT: begin
               state_q    <= block ^ round_key;
               round      <= 4'd1;
               word_ctr_q <= 2'd0;
               ctrl_q     <= CTRL_SBOX;
            end
            CTRL_SBOX: begin
               state_q    <= sbox_state;
               word_ctr_q <= word_ctr_q + 2'd1;
               if (word_ctr_q == 2'd3) begin
                  ctrl_q <= CTRL_MAIN;
               end
            end
            CTRL_MAIN: begin
               if (round < num_rounds_q) begin
                  state_q <= mc_state ^ round_key;
                  round   <= round + 4'd1;
                  ctrl_q  <= CTRL_SBOX;
               end else begin
                  // Final round omits MixColumns; round stays at num_rounds.
                  state_q <= sr_state ^ round_key;
                  ready   <= 1'b1;
                  ctrl_q  <= CTRL_IDLE;
               end
            end
            default: ctrl_q <= CTRL_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Bench for aes_encipher_block: models key_mem and the s_box, and checks
// against FIPS-197 vectors and a textbook byte-array AES model.
module tb_aes_encipher_block;

   logic         clk;
   logic         reset_n;
   logic         next;
   logic [3:0]   keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;

   int tests;
   int failed;

   logic [7:0]   sbox_t [256];
   logic [127:0] rk [16];

   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] KEY_C3 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

   aes_encipher_block dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .next      (next),
      .keylen    (keylen),
      .round     (round),
      .round_key (round_key),
      .sboxw     (sboxw),
      .new_sboxw (new_sboxw),
      .block     (block),
      .new_block (new_block),
      .ready     (ready)
   );

   assign new_sboxw = {sbox_t[sboxw[31:24]], sbox_t[sboxw[23:16]],
                       sbox_t[sboxw[15:8]],  sbox_t[sboxw[7:0]]};
   assign round_key = rk[round];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   // S-box from first principles: multiplicative inverse then affine map.
   task automatic build_sbox();
      logic [7:0] xb, inv;
      for (int x = 0; x < 256; x++) begin
         xb  = 8'(x);
         inv = 8'h0;
         if (x != 0) begin
            for (int y = 1; y < 256; y++) begin
               if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            end
         end
         sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                     {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   task automatic load_key(input logic [255:0] key, input int nk, input int nr);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] model(input logic [127:0] blk, input int nr);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a [4];
      logic [7:0]   coef [4];
      logic [127:0] k, out;
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      k = rk[0];
      for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ k[127-8*i -: 8];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
         if (r < nr) begin
            for (int c = 0; c < 4; c++) begin
               for (int j = 0; j < 4; j++) a[j] = t[4*c+j];
               for (int row = 0; row < 4; row++) begin
                  t[4*c+row] = 8'h0;
                  for (int j = 0; j < 4; j++)
                     t[4*c+row] = t[4*c+row] ^ gmul(coef[(j-row+4)%4], a[j]);
               end
            end
         end
         k = rk[r];
         for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
      return out;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      while (!ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // One encryption; optionally re-pulses next with new keylen/block mid-run.
   task automatic do_run(input logic [3:0] kl, input logic [127:0] blk, input int inject_at,
                         output int cyc, output logic [127:0] res,
                         output int max_rnd, output bit seq_ok);
      int last;
      @(negedge clk);
      keylen = kl;
      block  = blk;
      next   = 1'b1;
      @(negedge clk);
      next    = 1'b0;
      cyc     = 0;
      last    = int'(round);
      max_rnd = last;
      seq_ok  = (last == 0);
      while (!ready && cyc < 200) begin
         next = (cyc == inject_at);
         if (cyc == inject_at) begin
            keylen = 4'h2;
            block  = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         @(negedge clk);
         cyc++;
         if (int'(round) > max_rnd) max_rnd = int'(round);
         if (int'(round) != last) begin
            if (int'(round) != last + 1) seq_ok = 1'b0;
            last = int'(round);
         end
      end
      next = 1'b0;
      res  = new_block;
   endtask

   initial begin
      int           cyc, cyc2, max_rnd, nr, nk;
      bit           seq_ok;
      logic [127:0] res, res2, blk, expv;
      logic [255:0] key;
      logic [3:0]   kl;

      tests   = 0;
      failed  = 0;
      reset_n = 1'b1;
      next    = 1'b0;
      keylen  = 4'h0;
      block   = 128'h0;
      build_sbox();
      load_key(KEY_C1, 4, 10);
      #3 reset_n = 1'b0;
      #4;
      check("reset_ready", 128'(ready), 128'd1);
      check("reset_new_block", new_block, 128'h0);
      check("reset_round", 128'(round), 128'd0);
      check("reset_sboxw", 128'(sboxw), 128'h0);
      @(negedge clk);
      reset_n = 1'b1;

      do_run(4'h0, PT, -1, cyc, res, max_rnd, seq_ok);
      check("c1_cycles", 128'(cyc), 128'd51);
      check("c1_result", res, CT_C1);
      check("c1_model", model(PT, 10), CT_C1);

      load_key(KEY_C2, 6, 12);
      do_run(4'h1, PT, -1, cyc, res, max_rnd, seq_ok);
      check("c2_cycles", 128'(cyc), 128'd61);
      check("c2_result", res, CT_C2);

      load_key(KEY_C3, 8, 14);
      do_run(4'h2, PT, -1, cyc, res, max_rnd, seq_ok);
      check("c3_cycles", 128'(cyc), 128'd71);
      check("c3_result", res, CT_C3);
      check("c3_round_seq", 128'(seq_ok), 128'd1);
      check("c3_round_max", 128'(max_rnd), 128'd14);
      check("c3_hold", new_block, CT_C3);

      load_key(KEY_C1, 4, 10);
      do_run(4'h0, PT, 20, cyc, res, max_rnd, seq_ok);
      check("busy_next_cycles", 128'(cyc), 128'd51);
      check("busy_next_result", res, CT_C1);
      check("busy_next_round_max", 128'(max_rnd), 128'd10);

      // Abort at cycle 30: reset is asserted away from any clock edge.
      @(negedge clk);
      keylen = 4'h0;
      block  = PT;
      next   = 1'b1;
      @(negedge clk);
      next = 1'b0;
      repeat (29) @(negedge clk);
      check("pre_abort_busy", 128'(ready), 128'd0);
      #2 reset_n = 1'b0;
      #1;
      check("abort_ready", 128'(ready), 128'd1);
      check("abort_new_block", new_block, 128'h0);
      check("abort_round", 128'(round), 128'd0);
      @(negedge clk);
      reset_n = 1'b1;
      do_run(4'h0, PT, -1, cyc, res, max_rnd, seq_ok);
      check("post_abort_cycles", 128'(cyc), 128'd51);
      check("post_abort_result", res, CT_C1);

      do_run(4'h7, PT, -1, cyc, res, max_rnd, seq_ok);
      check("keylen7_cycles", 128'(cyc), 128'd51);
      check("keylen7_result", res, CT_C1);
      check("keylen7_round_max", 128'(max_rnd), 128'd10);

      // next held high: back-to-back runs with a single idle/ready cycle.
      @(negedge clk);
      keylen = 4'h7;
      block  = PT;
      next   = 1'b1;
      @(negedge clk);
      wait_ready(cyc);
      res = new_block;
      @(negedge clk);
      check("b2b_ready_gap", 128'(ready), 128'd0);
      wait_ready(cyc2);
      next = 1'b0;
      res2 = new_block;
      check("b2b_first_cycles", 128'(cyc), 128'd51);
      check("b2b_first_result", res, CT_C1);
      check("b2b_second_cycles", 128'(cyc2), 128'd51);
      check("b2b_second_result", res2, CT_C1);

      for (int n = 0; n < 6; n++) begin
         kl  = 4'($urandom_range(0, 2));
         nk  = 4 + 2 * int'(kl);
         nr  = 10 + 2 * int'(kl);
         key = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
         blk = {$urandom(), $urandom(), $urandom(), $urandom()};
         load_key(key, nk, nr);
         expv = model(blk, nr);
         do_run(kl, blk, -1, cyc, res, max_rnd, seq_ok);
         check($sformatf("rand%0d_cycles", n), 128'(cyc), 128'(1 + 5 * nr));
         check($sformatf("rand%0d_result", n), res, expv);
         check($sformatf("rand%0d_round_seq", n), 128'(seq_ok && max_rnd == nr), 128'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
